rx_lane_err_detect: RTL and testbench
=====================================

# rx_lane_err_detect

Per-lane error classifier and error-rate supervisor for the JESD204 RX link layer. Sits between the 8b10b decoder outputs of one lane and the lane's error counter. Each beat it classifies every octet as disparity error, not-in-table, or unexpected control character, and presents the result as a registered event vector. It also raises a resync request when the error count within a programmable beat window reaches a threshold.

## Interface
- DATA_PATH_WIDTH, 4: octets per beat.
- THRESH_WIDTH, 8: width of the threshold and of the window error accumulator.
- WINDOW_WIDTH, 16: width of the window length and the beat counter.
- clk  in  1  lane clock. One clock domain.
- resetn  in  1  asynchronous, active-low reset.
- active  in  1  lane is in data/ILAS phase; classification is enabled only while high.
- char  in  8*DATA_PATH_WIDTH  decoded octets; octet i is bits [8i+7:8i].
- charisk  in  DATA_PATH_WIDTH  control-character flag per octet.
- notintable  in  DATA_PATH_WIDTH  code-group-not-in-table flag per octet.
- disperr  in  DATA_PATH_WIDTH  running-disparity error flag per octet.
- cfg_err_threshold  in  THRESH_WIDTH  errors per window that trigger a request; 0 disables requests.
- cfg_window_len  in  WINDOW_WIDTH  window length in beats; 0 means the window never ends.
- cfg_resync_en  in  1  enables request generation.
- resync_ack  in  1  link-layer acknowledge of resync_req.
- error_event  out  3*DATA_PATH_WIDTH  [DPW-1:0] disparity, [2DPW-1:DPW] not-in-table, [3DPW-1:2DPW] unexpected-K. Bit i of each group is octet i.
- resync_req  out  1  level request, held until acknowledged.

## Operation
- Unexpected-K: charisk=1, notintable=0, and the octet is not one of 0xBC (K28.5), 0x1C (K28.0), 0x7C (K28.3), 0xFC (K28.7).
- notintable suppresses unexpected-K for the same octet. Disparity is flagged independently of the other two.
- If active=0, the registered error_event is all zeros.
- Accumulator acc: acc_next = acc + popcount(error_event), saturating at 2^THRESH_WIDTH-1. The popcount width is clog2(3*DPW+1).
- Beat counter win counts 0..cfg_window_len-1 while in MONITOR. On the beat where win = cfg_window_len-1:
  - that beat's errors take part in the threshold compare;
  - acc and win then clear to 0.
- FSM states:
  - IDLE: acc=0, win=0. Go to MONITOR when active=1.
  - MONITOR: if active=0, go to IDLE, clearing acc and win. Otherwise, if cfg_resync_en=1, cfg_err_threshold≠0 and acc_next ≥ cfg_err_threshold, go to REQUEST.
  - REQUEST: resync_req=1; acc and win are frozen. On resync_ack=1, go to WAIT_INACTIVE. A drop of active does not cancel the request.
  - WAIT_INACTIVE: go to IDLE when active=0. If active is already 0 on entry, IDLE follows on the next cycle.
- resync_req is a registered decode of state==REQUEST.
- error_event keeps updating in every state; only counting is FSM-gated.
- Config changes take effect immediately; no shadowing.

## Timing
- Reset values: error_event=0, resync_req=0, state=IDLE, acc=0, win=0.
- error_event latency: 1 cycle from the input beat.
- resync_req rises 2 cycles after the input beat that crosses the threshold.
- resync_req falls on the cycle after resync_ack is sampled high.
- If resync_ack is high in the same cycle REQUEST is entered, the request still shows for at least 1 cycle.
- Errors on the window-end beat count toward that window's compare, not the next one.
- resetn assertion mid-REQUEST drops resync_req asynchronously and returns to IDLE; there is no pending-request memory.

## Structure
- The shared jesd204 RX package holds:
  - the K-character constants 0xBC, 0x1C, 0x7C, 0xFC;
  - the event-group index localparams;
  - the FSM state encoding (IDLE, MONITOR, REQUEST, WAIT_INACTIVE).
- One sub-module, rx_octet_classify: purely combinational, one per octet, generated DATA_PATH_WIDTH times. Outputs the three per-octet flags.
- The popcount, saturating accumulator and FSM live in the top level.

## Test plan
- All octets 0xBC with charisk=1 and clean flags, active=1 -> error_event=0 throughout, resync_req stays 0.
- disperr=4'b0100 for one beat -> error_event=12'h004 exactly one cycle later, 0 afterwards.
- char octet1=0x5C, charisk=4'b0010; then same with notintable=4'b0010 -> first gives error_event=12'h200; second gives 12'h020 only.
- Threshold=3, window=8, one disparity error per beat for 3 beats -> resync_req high 2 cycles after the third beat; ack pulse -> low next cycle; active low -> IDLE.
- Threshold=3, window=4, 2 errors on beat 3 of window 0 and 2 errors on beat 0 of window 1 -> no request, because acc cleared at the boundary.
- resetn pulsed low while in REQUEST -> resync_req=0 immediately; after release, clean data gives no request.

Source files
------------

// File: rtl/rx_lane_err_detect_pkg.sv
// Shared JESD204 RX link-layer definitions.
// K characters, event-group indices and supervisor FSM states.
package rx_lane_err_detect_pkg;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_7 = 8'hFC;

    localparam int EV_DISP    = 0;
    localparam int EV_NIT     = 1;
    localparam int EV_UNEXP_K = 2;
    localparam int EV_GROUPS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MONITOR,
        ST_REQUEST,
        ST_WAIT_INACTIVE
    } rx_state_e;

    function automatic logic is_expected_k(input logic [7:0] octet);
        return (octet == K28_5) || (octet == K28_0) ||
               (octet == K28_3) || (octet == K28_7);
    endfunction

endpackage

// File: rtl/rx_lane_err_detect_if.sv
// Decoded lane beat from the 8b10b decoder plus the classified
// per-octet error events returned to the lane's error counter.
interface rx_lane_err_detect_if #(
    parameter int DATA_PATH_WIDTH = 4
) ();

    logic                           active;
    logic [8*DATA_PATH_WIDTH-1:0]   char;
    logic [DATA_PATH_WIDTH-1:0]     charisk;
    logic [DATA_PATH_WIDTH-1:0]     notintable;
    logic [DATA_PATH_WIDTH-1:0]     disperr;
    logic [3*DATA_PATH_WIDTH-1:0]   error_event;

    modport master (
        output active,
        output char,
        output charisk,
        output notintable,
        output disperr,
        input  error_event
    );

    modport slave (
        input  active,
        input  char,
        input  charisk,
        input  notintable,
        input  disperr,
        output error_event
    );

endinterface

// File: rtl/rx_lane_err_detect_octet_classify.sv
// Combinational classifier for one decoded octet.
// Not-in-table masks the unexpected-K flag; disparity is independent.
module rx_octet_classify
    import rx_lane_err_detect_pkg::*;
(
    input  logic [7:0] octet,
    input  logic       is_k,
    input  logic       nit,
    input  logic       derr,
    output logic       disp_err,
    output logic       nit_err,
    output logic       unexp_k
);

    // Flag each error class for this octet.
    always_comb begin
        disp_err = derr;
        nit_err  = nit;
        unexp_k  = is_k && !nit && !is_expected_k(octet);
    end

endmodule

// File: rtl/rx_lane_err_detect.sv
// Per-lane 8b10b error classifier with windowed error-rate
// supervision that raises a resync request to the link layer.
module rx_lane_err_detect
    import rx_lane_err_detect_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int THRESH_WIDTH    = 8,
    parameter int WINDOW_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    rx_lane_err_detect_if.slave     lane,
    input  logic [THRESH_WIDTH-1:0] cfg_err_threshold,
    input  logic [WINDOW_WIDTH-1:0] cfg_window_len,
    input  logic                    cfg_resync_en,
    input  logic                    resync_ack,
    output logic                    resync_req
);

    localparam int EVW   = EV_GROUPS * DATA_PATH_WIDTH;
    localparam int CNT_W = $clog2(EVW + 1);

    logic [DATA_PATH_WIDTH-1:0] disp_c;
    logic [DATA_PATH_WIDTH-1:0] nit_c;
    logic [DATA_PATH_WIDTH-1:0] unk_c;
    logic [EVW-1:0]             ev_q;
    logic [CNT_W-1:0]           ev_cnt;
    logic [THRESH_WIDTH:0]      acc_sum;
    logic [THRESH_WIDTH-1:0]    acc_next;
    logic [THRESH_WIDTH-1:0]    acc;
    logic [WINDOW_WIDTH-1:0]    win;
    logic                       win_last;
    logic                       trip;
    rx_state_e                  state;

    for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_oct
        rx_octet_classify u_oct (
            .octet    (lane.char[8*i +: 8]),
            .is_k     (lane.charisk[i]),
            .nit      (lane.notintable[i]),
            .derr     (lane.disperr[i]),
            .disp_err (disp_c[i]),
            .nit_err  (nit_c[i]),
            .unexp_k  (unk_c[i])
        );
    end

    // Register the event vector; blanked while the lane is inactive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ev_q <= '0;
        end else if (lane.active) begin
            ev_q <= {unk_c, nit_c, disp_c};
        end else begin
            ev_q <= '0;
        end
    end

    assign lane.error_event = ev_q;

    // Count events this beat and form the saturating running total.
    always_comb begin
        ev_cnt = '0;
        for (int i = 0; i < EVW; i++) begin
            ev_cnt = ev_cnt + CNT_W'(ev_q[i]);
        end
        acc_sum  = {1'b0, acc} + (THRESH_WIDTH + 1)'(ev_cnt);
        acc_next = acc_sum[THRESH_WIDTH] ? '1
                                         : acc_sum[THRESH_WIDTH-1:0];
        win_last = (cfg_window_len != '0) &&
                   (win == cfg_window_len - WINDOW_WIDTH'(1));
        trip     = cfg_resync_en && (cfg_err_threshold != '0) &&
                   (acc_next >= cfg_err_threshold);
    end

    // Supervisor FSM with window accounting and registered request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            acc        <= '0;
            win        <= '0;
            resync_req <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    acc        <= '0;
                    win        <= '0;
                    resync_req <= 1'b0;
                    if (lane.active) begin
                        state <= ST_MONITOR;
                    end
                end
                ST_MONITOR: begin
                    if (!lane.active) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        win   <= '0;
                    end else begin
                        if (trip) begin
                            state      <= ST_REQUEST;
                            resync_req <= 1'b1;
                        end
                        if (win_last) begin
                            acc <= '0;
                            win <= '0;
                        end else begin
                            acc <= acc_next;
                            if (cfg_window_len != '0) begin
                                win <= win + WINDOW_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_REQUEST: begin
                    if (resync_ack) begin
                        state      <= ST_WAIT_INACTIVE;
                        resync_req <= 1'b0;
                    end
                end
                ST_WAIT_INACTIVE: begin
                    resync_req <= 1'b0;
                    if (!lane.active) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resync_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_lane_err_detect.sv
// Self-checking bench for rx_lane_err_detect.
// Directed scenarios plus randomized beats against a reference model.
module tb_rx_lane_err_detect;

    localparam int M_IDLE = 10;
    localparam int M_MON  = 11;
    localparam int M_REQ  = 12;
    localparam int M_WAIT = 13;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  cfg_err_threshold = '0;
    logic [15:0] cfg_window_len = '0;
    logic        cfg_resync_en = 1'b0;
    logic        resync_ack = 1'b0;
    logic        resync_req;

    int errors = 0;
    int checks = 0;

    int          m_mode;
    int          m_acc;
    int          m_win;
    logic [11:0] m_ev;
    logic        m_req;

    rx_lane_err_detect_if #(.DATA_PATH_WIDTH(4)) lane ();

    rx_lane_err_detect #(
        .DATA_PATH_WIDTH (4),
        .THRESH_WIDTH    (8),
        .WINDOW_WIDTH    (16)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .lane              (lane),
        .cfg_err_threshold (cfg_err_threshold),
        .cfg_window_len    (cfg_window_len),
        .cfg_resync_en     (cfg_resync_en),
        .resync_ack        (resync_ack),
        .resync_req        (resync_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_ev(
        input logic a, input logic [31:0] c, input logic [3:0] k,
        input logic [3:0] n, input logic [3:0] d);
        logic [11:0] r;
        logic [7:0]  o;
        r = '0;
        if (a) begin
            for (int i = 0; i < 4; i++) begin
                o = c[8*i +: 8];
                if (d[i]) r[i] = 1'b1;
                if (n[i]) r[4+i] = 1'b1;
                else if (k[i] && !(o inside {8'hBC, 8'h1C, 8'h7C, 8'hFC}))
                    r[8+i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_acc  = 0;
        m_win  = 0;
        m_ev   = '0;
        m_req  = 1'b0;
    endtask

    task automatic drive(input logic a, input logic [31:0] c,
                         input logic [3:0] k, input logic [3:0] n,
                         input logic [3:0] d);
        lane.active     = a;
        lane.char       = c;
        lane.charisk    = k;
        lane.notintable = n;
        lane.disperr    = d;
    endtask

    task automatic clean(input logic a);
        drive(a, {4{8'hBC}}, 4'hF, 4'h0, 4'h0);
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic step();
        logic [11:0] ev_n;
        int mode_n, acc_n, win_n, sum, len;
        ev_n   = model_ev(lane.active, lane.char, lane.charisk,
                          lane.notintable, lane.disperr);
        mode_n = m_mode;
        acc_n  = m_acc;
        win_n  = m_win;
        len    = int'(cfg_window_len);
        case (m_mode)
            M_IDLE: begin
                acc_n = 0;
                win_n = 0;
                if (lane.active) mode_n = M_MON;
            end
            M_MON: begin
                if (!lane.active) begin
                    mode_n = M_IDLE;
                    acc_n  = 0;
                    win_n  = 0;
                end else begin
                    sum = m_acc + $countones(m_ev);
                    if (sum > 255) sum = 255;
                    if (cfg_resync_en && cfg_err_threshold != 0 &&
                        sum >= int'(cfg_err_threshold))
                        mode_n = M_REQ;
                    if (len != 0 && m_win == len - 1) begin
                        acc_n = 0;
                        win_n = 0;
                    end else begin
                        acc_n = sum;
                        if (len != 0) win_n = (m_win + 1) % 65536;
                    end
                end
            end
            M_REQ: if (resync_ack) mode_n = M_WAIT;
            default: if (!lane.active) mode_n = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        m_ev   = ev_n;
        m_mode = mode_n;
        m_acc  = acc_n;
        m_win  = win_n;
        m_req  = (m_mode == M_REQ);
        check("error_event", 32'(lane.error_event), 32'(m_ev));
        check("resync_req", 32'(resync_req), 32'(m_req));
    endtask

    task automatic go_idle();
        clean(1'b0);
        resync_ack = 1'b0;
        repeat (3) step();
    endtask

    // Three single-error beats at threshold 3, window 8.
    task automatic reach_request();
        go_idle();
        cfg_err_threshold = 8'd3;
        cfg_window_len    = 16'd8;
        cfg_resync_en     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {4{8'hBC}}, 4'hF, 4'h0, 4'b0001);
            step();
        end
        check("req_before_rise", 32'(resync_req), 32'd0);
        clean(1'b1);
        step();
        check("req_rise", 32'(resync_req), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        clean(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_event", 32'(lane.error_event), 32'd0);
        check("reset_req", 32'(resync_req), 32'd0);
        resetn = 1'b1;

        // Valid K28.5 stream is error free.
        clean(1'b1);
        repeat (6) step();
        check("k285_clean", 32'(lane.error_event), 32'd0);
        check("k285_noreq", 32'(resync_req), 32'd0);

        // Single disparity error on octet 2.
        drive(1'b1, {4{8'hBC}}, 4'hF, 4'h0, 4'b0100);
        step();
        check("disp_oct2", 32'(lane.error_event), 32'h004);
        clean(1'b1);
        step();
        check("disp_clear", 32'(lane.error_event), 32'h000);

        // Unexpected K, then masked by not-in-table.
        drive(1'b1, 32'hBCBC5CBC, 4'b0010, 4'h0, 4'h0);
        step();
        check("unexp_k", 32'(lane.error_event), 32'h200);
        drive(1'b1, 32'hBCBC5CBC, 4'b0010, 4'b0010, 4'h0);
        step();
        check("nit_masks_k", 32'(lane.error_event), 32'h020);

        // Inactive lane blanks events.
        drive(1'b0, 32'h12345678, 4'hF, 4'hF, 4'hF);
        step();
        check("inactive_blank", 32'(lane.error_event), 32'h000);

        // Threshold crossing, ack, release.
        reach_request();
        step();
        check("req_hold", 32'(resync_req), 32'd1);
        resync_ack = 1'b1;
        step();
        check("req_fall", 32'(resync_req), 32'd0);
        resync_ack = 1'b0;
        clean(1'b0);
        repeat (3) step();
        check("after_idle", 32'(resync_req), 32'd0);

        // Errors straddling a window boundary do not combine.
        go_idle();
        cfg_err_threshold = 8'd3;
        cfg_window_len    = 16'd4;
        cfg_resync_en     = 1'b1;
        for (int b = 0; b < 10; b++) begin
            if (b == 3 || b == 4)
                drive(1'b1, {4{8'hBC}}, 4'hF, 4'h0, 4'b0011);
            else
                clean(1'b1);
            step();
        end
        check("window_split", 32'(resync_req), 32'd0);

        // Asynchronous reset during a request.
        reach_request();
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_req", 32'(resync_req), 32'd0);
        check("async_rst_ev", 32'(lane.error_event), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        clean(1'b1);
        repeat (12) step();
        check("post_rst_noreq", 32'(resync_req), 32'd0);

        // Randomized traffic with occasional reconfiguration.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [31:0] c;
            logic [3:0]  k, n, d;
            if (cyc % 250 == 0) begin
                cfg_err_threshold = 8'($urandom_range(0, 10));
                cfg_window_len    = 16'($urandom_range(0, 12));
                cfg_resync_en     = ($urandom_range(0, 7) != 0);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 3))
                        0: c[8*i +: 8] = 8'hBC;
                        1: c[8*i +: 8] = 8'h1C;
                        2: c[8*i +: 8] = 8'h7C;
                        default: c[8*i +: 8] = 8'hFC;
                    endcase
                    k[i] = ($urandom_range(0, 1) == 1);
                end else begin
                    c[8*i +: 8] = 8'($urandom);
                    k[i] = ($urandom_range(0, 7) == 0);
                end
                n[i] = ($urandom_range(0, 15) == 0);
                d[i] = ($urandom_range(0, 15) == 0);
            end
            drive(($urandom_range(0, 39) != 0), c, k, n, d);
            if (resync_req)
                resync_ack = ($urandom_range(0, 3) == 0);
            else
                resync_ack = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
